// File: rtl/wf_stopwatch_core_if.sv
// Signal bundle between the stopwatch core and its controller/display side.
// Lap signals exist only when WF_STOPWATCH_LAP_EN is defined.
interface wf_stopwatch_core_if;
    logic       tick;
    logic       start_stop;
    logic       clear_hold;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [1:0] colon;
    logic       running;
    logic       overflow;
`ifdef WF_STOPWATCH_LAP_EN
    logic       lap;
    logic       lap_active;
`endif

    modport master (
`ifdef WF_STOPWATCH_LAP_EN
        output lap,
        input  lap_active,
`endif
        output tick, start_stop, clear_hold,
        input  digit0, digit1, digit2, digit3, colon, running, overflow
    );

    modport slave (
`ifdef WF_STOPWATCH_LAP_EN
        input  lap,
        output lap_active,
`endif
        input  tick, start_stop, clear_hold,
        output digit0, digit1, digit2, digit3, colon, running, overflow
    );
endinterface

// File: rtl/wf_stopwatch_core.sv
// BCD stopwatch engine (SS.hh or MM:SS) with IDLE/RUN/PAUSE control, hold-to-clear
// and blinking separator in PAUSE. Optional lap display: define WF_STOPWATCH_LAP_EN.
module wf_stopwatch_core #(
    parameter int MMSS        = 0,
    parameter int HOLD_TICKS  = 100,
    parameter int BLINK_TICKS = 50
) (
    input  logic                 clk,
    input  logic                 reset,
    wf_stopwatch_core_if.slave   sw
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    localparam logic [3:0] D1_MAX     = (MMSS != 0) ? 4'd5 : 4'd9;
    localparam logic [1:0] COLON_BASE = (MMSS != 0) ? 2'b00 : 2'b01;
    localparam logic [9:0] HOLD_MAX   = 10'(HOLD_TICKS);
    localparam logic [9:0] HOLD_LAST  = 10'(HOLD_TICKS - 1);
    localparam logic [9:0] BLINK_LAST = 10'(BLINK_TICKS - 1);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic        overflow_q, overflow_d;
    logic [9:0]  hold_q, hold_d;
    logic [9:0]  blink_q, blink_d;
    logic        phase_q, phase_d;
    logic        running_q, running_d;
    logic        clear_evt;
    logic [16:0] count_inc;
    logic [15:0] disp;

    // Returns {wrap, d3, d2, d1, d0}; carries ripple through all digits in one step.
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [3:0] d0, d1, d2, d3;
        logic       c0, c1, c2, c3;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        d3 = v[15:12];
        c0 = (d0 == 4'd9);
        c1 = c0 && (d1 == D1_MAX);
        c2 = c1 && (d2 == 4'd9);
        c3 = c2 && (d3 == 4'd9);
        d0 = c0 ? 4'd0 : d0 + 4'd1;
        if (c0) d1 = c1 ? 4'd0 : d1 + 4'd1;
        if (c1) d2 = c2 ? 4'd0 : d2 + 4'd1;
        if (c2) d3 = c3 ? 4'd0 : d3 + 4'd1;
        return {c3, d3, d2, d1, d0};
    endfunction

    assign clear_evt = sw.clear_hold && sw.tick && (hold_q == HOLD_LAST);
    assign count_inc = bcd_inc(count_q);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        hold_d     = hold_q;
        blink_d    = blink_q;
        phase_d    = phase_q;

        // Hold counter saturates at HOLD_TICKS so a clear fires once per press.
        if (!sw.clear_hold) begin
            hold_d = '0;
        end else if (sw.tick && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 10'd1;
        end

        if (clear_evt) begin
            state_d    = IDLE;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if ((state_q == RUN) && sw.tick) begin
                count_d = count_inc[15:0];
                if (count_inc[16]) overflow_d = 1'b1;
            end
            unique case (state_q)
                IDLE:    if (sw.start_stop) state_d = RUN;
                RUN:     if (sw.start_stop) state_d = PAUSE;
                PAUSE:   if (sw.start_stop) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end

        if ((state_d != PAUSE) || (state_q != PAUSE)) begin
            blink_d = '0;
            phase_d = 1'b0;
        end else if (sw.tick) begin
            if (blink_q == BLINK_LAST) begin
                blink_d = '0;
                phase_d = !phase_q;
            end else begin
                blink_d = blink_q + 10'd1;
            end
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
            hold_q     <= '0;
            blink_q    <= '0;
            phase_q    <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            hold_q     <= hold_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
            running_q  <= running_d;
        end
    end

`ifdef WF_STOPWATCH_LAP_EN
    logic        lap_active_q, lap_active_d;
    logic [15:0] shadow_q, shadow_d;

    always_comb begin
        lap_active_d = lap_active_q;
        shadow_d     = shadow_q;
        if (clear_evt || ((state_d == PAUSE) && (state_q != PAUSE))) begin
            lap_active_d = 1'b0;
        end else if ((state_q == RUN) && sw.lap) begin
            if (!lap_active_q) begin
                shadow_d     = count_q;
                lap_active_d = 1'b1;
            end else begin
                lap_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_active_q <= 1'b0;
            shadow_q     <= '0;
        end else begin
            lap_active_q <= lap_active_d;
            shadow_q     <= shadow_d;
        end
    end

    assign disp          = lap_active_q ? shadow_q : count_q;
    assign sw.lap_active = lap_active_q;
`else
    assign disp = count_q;
`endif

    assign sw.digit0   = disp[3:0];
    assign sw.digit1   = disp[7:4];
    assign sw.digit2   = disp[11:8];
    assign sw.digit3   = disp[15:12];
    assign sw.colon    = ((state_q == PAUSE) && phase_q) ? 2'b11 : COLON_BASE;
    assign sw.running  = running_q;
    assign sw.overflow = overflow_q;

endmodule

// File: tb/tb_wf_stopwatch_core.sv
// Directed bench: SS.hh instance driven from a vector table, MM:SS instance by hand.
module tb_wf_stopwatch_core;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;

    wf_stopwatch_core_if if0 ();
    wf_stopwatch_core_if if1 ();

    wf_stopwatch_core #(.MMSS(0), .HOLD_TICKS(100), .BLINK_TICKS(2)) u_ss (
        .clk(clk), .reset(reset), .sw(if0.slave));
    wf_stopwatch_core #(.MMSS(1), .HOLD_TICKS(3), .BLINK_TICKS(50)) u_mm (
        .clk(clk), .reset(reset), .sw(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        tk;
        logic        ss;
        logic        ch;
        int          n;
        logic [15:0] dig;
        logic [1:0]  col;
        logic        run;
        logic        ovf;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive0(input logic tk, input logic ss, input logic ch, input int n);
        if0.tick = tk; if0.start_stop = ss; if0.clear_hold = ch;
        cycles(n);
    endtask

    task automatic drive1(input logic tk, input logic ss, input logic ch, input int n);
        if1.tick = tk; if1.start_stop = ss; if1.clear_hold = ch;
        cycles(n);
    endtask

    function automatic logic [15:0] dig0();
        return {if0.digit3, if0.digit2, if0.digit1, if0.digit0};
    endfunction

    function automatic logic [15:0] dig1();
        return {if1.digit3, if1.digit2, if1.digit1, if1.digit0};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        drive0(0, 0, 0, 2);
        drive1(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        if0.tick = 0; if0.start_stop = 0; if0.clear_hold = 0;
        if1.tick = 0; if1.start_stop = 0; if1.clear_hold = 0;
`ifdef WF_STOPWATCH_LAP_EN
        if0.lap = 0;
        if1.lap = 0;
`endif

        //              tk ss ch   n      dig        col    run  ovf
        vt[0]  = '{1'b0, 1'b1, 1'b0, 1,    16'h0000, 2'b01, 1'b1, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 250,  16'h0250, 2'b01, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 1,    16'h0251, 2'b01, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1'b0, 1,    16'h0251, 2'b01, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 1,    16'h0251, 2'b11, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 1'b0, 1,    16'h0251, 2'b11, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 1,    16'h0251, 2'b01, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 1,    16'h0251, 2'b01, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 9748, 16'h9999, 2'b01, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1,    16'h0000, 2'b01, 1'b1, 1'b1};
        vt[10] = '{1'b1, 1'b0, 1'b0, 5,    16'h0005, 2'b01, 1'b1, 1'b1};
        vt[11] = '{1'b1, 1'b0, 1'b1, 99,   16'h0104, 2'b01, 1'b1, 1'b1};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1,    16'h0104, 2'b01, 1'b1, 1'b1};
        vt[13] = '{1'b1, 1'b0, 1'b1, 99,   16'h0203, 2'b01, 1'b1, 1'b1};
        vt[14] = '{1'b1, 1'b1, 1'b1, 1,    16'h0000, 2'b01, 1'b0, 1'b0};
        vt[15] = '{1'b1, 1'b0, 1'b1, 3,    16'h0000, 2'b01, 1'b0, 1'b0};
        vt[16] = '{1'b0, 1'b1, 1'b1, 1,    16'h0000, 2'b01, 1'b1, 1'b0};
        vt[17] = '{1'b1, 1'b0, 1'b1, 3,    16'h0003, 2'b01, 1'b1, 1'b0};
        vt[18] = '{1'b0, 1'b1, 1'b0, 1,    16'h0003, 2'b01, 1'b0, 1'b0};

        do_reset();
        chk("rst_ss_digits", 32'(dig0()), 32'h0);
        chk("rst_ss_colon", 32'(if0.colon), 32'h1);
        chk("rst_ss_running", 32'(if0.running), 32'h0);
        chk("rst_ss_overflow", 32'(if0.overflow), 32'h0);
        chk("rst_mm_digits", 32'(dig1()), 32'h0);
        chk("rst_mm_colon", 32'(if1.colon), 32'h0);

        for (int v = 0; v < 19; v++) begin
            drive0(vt[v].tk, vt[v].ss, vt[v].ch, vt[v].n);
            chk($sformatf("vec%0d_digits", v), 32'(dig0()), 32'(vt[v].dig));
            chk($sformatf("vec%0d_colon", v), 32'(if0.colon), 32'(vt[v].col));
            chk($sformatf("vec%0d_running", v), 32'(if0.running), 32'(vt[v].run));
            chk($sformatf("vec%0d_overflow", v), 32'(if0.overflow), 32'(vt[v].ovf));
        end
        drive0(0, 0, 0, 1);

        // Reset while holding clear must also zero the hold counter.
        drive0(0, 1, 0, 1);
        drive0(1, 0, 1, 60);
        do_reset();
        chk("midrst_digits", 32'(dig0()), 32'h0);
        chk("midrst_running", 32'(if0.running), 32'h0);
        drive0(0, 1, 0, 1);
        drive0(1, 0, 1, 99);
        chk("midrst_noclear_digits", 32'(dig0()), 32'h0099);
        chk("midrst_noclear_running", 32'(if0.running), 32'h1);
        drive0(0, 0, 0, 1);

        // MM:SS instance: digit1 wraps at 5, full wrap at 99:59.
        drive1(0, 1, 0, 1);
        drive1(1, 0, 0, 599);
        chk("mm_0959", 32'(dig1()), 32'h0959);
        drive1(1, 0, 0, 1);
        chk("mm_1000", 32'(dig1()), 32'h1000);
        drive1(1, 0, 0, 5399);
        chk("mm_9959", 32'(dig1()), 32'h9959);
        chk("mm_9959_ovf", 32'(if1.overflow), 32'h0);
        drive1(1, 0, 0, 1);
        chk("mm_wrap_digits", 32'(dig1()), 32'h0000);
        chk("mm_wrap_ovf", 32'(if1.overflow), 32'h1);
        chk("mm_wrap_running", 32'(if1.running), 32'h1);
        chk("mm_colon", 32'(if1.colon), 32'h0);
        drive1(1, 0, 1, 2);
        chk("mm_hold_counts", 32'(dig1()), 32'h0002);
        chk("mm_hold_ovf", 32'(if1.overflow), 32'h1);
        drive1(1, 0, 1, 1);
        chk("mm_clear_digits", 32'(dig1()), 32'h0000);
        chk("mm_clear_ovf", 32'(if1.overflow), 32'h0);
        chk("mm_clear_running", 32'(if1.running), 32'h0);
        drive1(0, 0, 0, 1);

`ifdef WF_STOPWATCH_LAP_EN
        do_reset();
        chk("lap_rst", 32'(if0.lap_active), 32'h0);
        drive0(0, 1, 0, 1);
        drive0(1, 0, 0, 1234);
        chk("lap_pre", 32'(dig0()), 32'h1234);
        if0.lap = 1;
        drive0(0, 0, 0, 1);
        if0.lap = 0;
        chk("lap_active_set", 32'(if0.lap_active), 32'h1);
        drive0(1, 0, 0, 10);
        chk("lap_frozen", 32'(dig0()), 32'h1234);
        if0.lap = 1;
        drive0(0, 0, 0, 1);
        if0.lap = 0;
        chk("lap_release", 32'(dig0()), 32'h1244);
        chk("lap_active_clr", 32'(if0.lap_active), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wf_stopwatch_core.md
Name: wf_stopwatch_core

Overview:
- BCD stopwatch counting engine with run/pause/clear control FSM.
- Sits directly upstream of the 4-digit serial 7-segment interface.
- Drives that interface's digit0..digit3 and colon inputs.
- Consumes a count tick from the WF_timer chain, plus a debounced button (pulse and level) and a CPU toggle pulse. Replaces the ad-hoc counter/control logic in top-level demos.

Parameters:
- MMSS, 0: 0 = SS.hh format (00.00–99.99, tick = 10 ms); 1 = MM:SS format (00:00–99:59, tick = 1 s).
- HOLD_TICKS, 100: consecutive ticks with clear_hold high required to clear; range 1–1023.
- BLINK_TICKS, 50: ticks per blink half-period of the separator in PAUSE; range 1–1023.

Ports:
- clk  in  1  system clock (12 MHz HFOSC)
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-clk pulse per count unit
- start_stop  in  1  one-clk pulse; toggles run/pause
- clear_hold  in  1  level, high while the clear button is held (already synchronised)
- digit0  out  4  BCD least-significant digit
- digit1  out  4  BCD
- digit2  out  4  BCD
- digit3  out  4  BCD most-significant digit
- colon  out  2  separator code: 00 colon, 01 decimal point, 11 none
- running  out  1  high in RUN
- overflow  out  1  sticky; set when the count wraps

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, port reset. All state is sampled on posedge clk.
- Reset values:
  - digits all 0
  - state IDLE
  - running 0, overflow 0
  - hold counter 0, blink counter 0, blink phase 0
  - colon = 01 if MMSS=0, 00 if MMSS=1
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start_stop -> RUN
  - RUN + start_stop -> PAUSE
  - PAUSE + start_stop -> RUN
  - Clear event (any state) -> IDLE
- Counting:
  - Only in RUN, on tick. Digits and overflow update on the edge that samples tick (1-cycle latency).
  - The increment uses the pre-transition state. In RUN, tick and start_stop in the same cycle: the tick counts and the state goes to PAUSE.
  - In PAUSE, tick and start_stop together: the tick is not counted and the state goes to RUN.
- BCD arithmetic:
  - digit0 counts 0–9.
  - digit1 wraps at 9 (MMSS=0) or 5 (MMSS=1).
  - digit2 counts 0–9; digit3 counts 0–9.
  - Each carry ripples within the same cycle.
  - Wrap from max (99.99 or 99:59) goes to all zeros and sets overflow.
  - No digit ever holds a value above 9, or digit1 above 5 in MMSS mode.
- Clear:
  - The hold counter increments on each tick while clear_hold=1, and resets to 0 in any cycle where clear_hold=0.
  - When the count reaches HOLD_TICKS, a clear event fires for that cycle: digits go to 0, overflow to 0, state to IDLE, and the hold counter saturates.
  - No re-fire until clear_hold drops.
  - A clear event beats start_stop and tick arriving in the same cycle.
- Colon:
  - In IDLE/RUN: steady base code (01 if MMSS=0, 00 if MMSS=1).
  - On entry to PAUSE: blink counter cleared, phase 0.
  - In PAUSE: every BLINK_TICKS ticks the phase toggles; phase 1 outputs 11.
  - On leaving PAUSE: colon returns to the base code on the next edge.
- running = (state==RUN), registered.
- Reset mid-count or mid-hold: all state returns to reset values on the next edge; no partial clear.

Optional Feature:
- Macro WF_STOPWATCH_LAP_EN.
- When defined:
  - Adds input lap (1-clk pulse) and output lap_active (1 bit, reset 0).
  - In RUN, lap with lap_active=0 latches the live count into shadow registers and sets lap_active. Digits then show the shadow while the live count continues.
  - In RUN, lap with lap_active=1 clears lap_active; digits show the live count next edge.
  - Entering PAUSE or a clear event clears lap_active.
  - lap is ignored in IDLE and PAUSE.
- When undefined: no lap/lap_active ports; digits always reflect the live count.

Test Plan:
- Reset, MMSS=0, one start_stop, then 250 ticks -> running=1, digits 3..0 = 0,2,5,0; colon=01.
- MMSS=1, preload by ticks to 09:59, one more tick -> 10:00.
- MMSS=1, preload to 99:59, one more tick -> 00:00, overflow=1, still RUN.
- RUN, start_stop and tick in the same cycle -> count +1 and PAUSE.
- In PAUSE with BLINK_TICKS=2, 4 ticks -> colon sequence 01, 11, 01.
- clear_hold high for 99 ticks, low 1 cycle, high 100 ticks -> no clear after the 99; clear at the 100th tick, with digits=0, overflow=0, IDLE. A start_stop pulse in the clear cycle is ignored.
- WF_STOPWATCH_LAP_EN: RUN at 12.34, lap, then 10 ticks -> digits stay 12.34; second lap -> 12.44, lap_active=0.
